// File: rtl/axi_lite_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_arb_pkg
// Shared definitions for the AXI4-Lite arbiter: the arbiter FSM state type
// and the default address/data widths used by the top level.
// ---------------------------------------------------------------------------
package axi_lite_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // One transaction at a time: a write walks AW -> W -> B, a read AR -> R.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
// Ports:
//   req    in  N    request vector
//   ptr    in  IDW  highest-priority index for this decision
//   gnt    out N    one-hot grant (all zero when nothing requests)
//   gnt_id out IDW  index of the granted requester
//   any    out 1    at least one request is active
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    int w_idx;

    // Scan ptr, ptr+1, ... (mod N); the first active request wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        w_idx  = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!any && req[w_idx]) begin
                any        = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_arbiter
// Shares one AXI4-Lite slave between NUM_MASTERS masters. Round-robin grant
// per transaction, one transaction outstanding on the slave at a time, and
// each write is serialised AW, then W, then B.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*           per-master write channels (packed, master i at
//   s_ar*/s_r*                [i*W +: W]); s_rdata is broadcast, qualified by
//                             s_rvalid[i]
//   m_aw*/m_w*/m_b*/m_ar*/m_r* slave-side AXI4-Lite channels
//   grant_id                  granted master, meaningful while busy=1
//   busy                      high in any state other than IDLE
// ---------------------------------------------------------------------------
module axi_lite_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_W      = ARB_ADDR_W,
    parameter  int DATA_W      = ARB_DATA_W,
    localparam int IDW         = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_MASTERS-1:0]        s_awvalid,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_awaddr,
    output logic [NUM_MASTERS-1:0]        s_awready,
    input  logic [NUM_MASTERS-1:0]        s_wvalid,
    input  logic [NUM_MASTERS*DATA_W-1:0] s_wdata,
    output logic [NUM_MASTERS-1:0]        s_wready,
    output logic [NUM_MASTERS-1:0]        s_bvalid,
    input  logic [NUM_MASTERS-1:0]        s_bready,
    input  logic [NUM_MASTERS-1:0]        s_arvalid,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
    output logic [NUM_MASTERS-1:0]        s_arready,
    output logic [NUM_MASTERS-1:0]        s_rvalid,
    output logic [DATA_W-1:0]             s_rdata,
    input  logic [NUM_MASTERS-1:0]        s_rready,
    output logic                          m_awvalid,
    output logic [ADDR_W-1:0]             m_awaddr,
    input  logic                          m_awready,
    output logic                          m_wvalid,
    output logic [DATA_W-1:0]             m_wdata,
    input  logic                          m_wready,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic                          m_arvalid,
    output logic [ADDR_W-1:0]             m_araddr,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic [DATA_W-1:0]             m_rdata,
    output logic                          m_rready,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    arb_state_t       r_state;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_rr_ptr;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic [IDW-1:0]         w_gnt_id;
    logic                   w_any;
    logic                   w_gnt_is_wr;
    logic [IDW-1:0]         w_next_ptr;
    logic                   w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    logic [ADDR_W-1:0] w_awaddr [NUM_MASTERS];
    logic [DATA_W-1:0] w_wdata  [NUM_MASTERS];
    logic [ADDR_W-1:0] w_araddr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign w_awaddr[i] = s_awaddr[i*ADDR_W +: ADDR_W];
        assign w_wdata[i]  = s_wdata[i*DATA_W +: DATA_W];
        assign w_araddr[i] = s_araddr[i*ADDR_W +: ADDR_W];
    end

    assign w_req = s_awvalid | s_arvalid;

    rr_arbiter #(
        .N   (NUM_MASTERS),
        .IDW (IDW)
    ) u_rr (
        .req    (w_req),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    // A master with both AW and AR pending is served its write first.
    assign w_gnt_is_wr = |(w_gnt & s_awvalid);

    assign w_next_ptr = (r_grant == IDW'(NUM_MASTERS - 1)) ? '0 : r_grant + IDW'(1);

    assign w_aw_hs = m_awvalid & m_awready;
    assign w_w_hs  = m_wvalid  & m_wready;
    assign w_b_hs  = m_bvalid  & m_bready;
    assign w_ar_hs = m_arvalid & m_arready;
    assign w_r_hs  = m_rvalid  & m_rready;

    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign s_rdata  = m_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_gnt_id;
                        r_state <= w_gnt_is_wr ? ST_WR_ADDR : ST_RD_ADDR;
                    end
                end
                ST_WR_ADDR: if (w_aw_hs) r_state <= ST_WR_DATA;
                ST_WR_DATA: if (w_w_hs)  r_state <= ST_WR_RESP;
                ST_WR_RESP: begin
                    if (w_b_hs) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                ST_RD_ADDR: if (w_ar_hs) r_state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    if (w_r_hs) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Only the channel belonging to the current state is connected, and only
    // for the granted master; everything else is held at 0.
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awaddr  = w_awaddr[r_grant];
        m_wdata   = w_wdata[r_grant];
        m_araddr  = w_araddr[r_grant];
        case (r_state)
            ST_WR_ADDR: begin
                m_awvalid          = s_awvalid[r_grant];
                s_awready[r_grant] = m_awready;
            end
            ST_WR_DATA: begin
                m_wvalid          = s_wvalid[r_grant];
                s_wready[r_grant] = m_wready;
            end
            ST_WR_RESP: begin
                s_bvalid[r_grant] = m_bvalid;
                m_bready          = s_bready[r_grant];
            end
            ST_RD_ADDR: begin
                m_arvalid          = s_arvalid[r_grant];
                s_arready[r_grant] = m_arready;
            end
            ST_RD_DATA: begin
                s_rvalid[r_grant] = m_rvalid;
                m_rready          = s_rready[r_grant];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_awaddr, s_wdata, s_araddr;
    logic [31:0] s_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [0:0]  grant_id;
    logic        busy;

    // master-side drive, one element per master so forked masters never share a variable
    logic        tb_awvalid[2], tb_wvalid[2], tb_bready[2], tb_arvalid[2], tb_rready[2];
    logic [31:0] tb_awaddr[2], tb_wdata[2], tb_araddr[2];

    assign s_awvalid = {tb_awvalid[1], tb_awvalid[0]};
    assign s_wvalid  = {tb_wvalid[1],  tb_wvalid[0]};
    assign s_bready  = {tb_bready[1],  tb_bready[0]};
    assign s_arvalid = {tb_arvalid[1], tb_arvalid[0]};
    assign s_rready  = {tb_rready[1],  tb_rready[0]};
    assign s_awaddr  = {tb_awaddr[1],  tb_awaddr[0]};
    assign s_wdata   = {tb_wdata[1],   tb_wdata[0]};
    assign s_araddr  = {tb_araddr[1],  tb_araddr[0]};

    axi_lite_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
        .grant_id(grant_id), .busy(busy)
    );

    // ---------------- 16-word slave model ----------------
    logic        sl_awready, sl_wready, sl_arready;
    logic        sl_bvalid, sl_rvalid;
    logic [31:0] sl_rdata;
    logic [3:0]  sl_awidx;
    logic [31:0] mem [16];

    assign m_awready = sl_awready;
    assign m_wready  = sl_wready;
    assign m_arready = sl_arready;
    assign m_bvalid  = sl_bvalid;
    assign m_rvalid  = sl_rvalid;
    assign m_rdata   = sl_rdata;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sl_bvalid <= 1'b0;
            sl_rvalid <= 1'b0;
            sl_rdata  <= '0;
            sl_awidx  <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (m_awvalid && m_awready) sl_awidx <= m_awaddr[5:2];
            if (m_wvalid && m_wready) begin
                mem[sl_awidx] <= m_wdata;
                sl_bvalid     <= 1'b1;
            end
            if (m_bvalid && m_bready) sl_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                sl_rvalid <= 1'b1;
                sl_rdata  <= mem[m_araddr[5:2]];
            end
            if (m_rvalid && m_rready) sl_rvalid <= 1'b0;
        end
    end

    // ---------------- monitors ----------------
    logic aw_seen;
    int   early_w = 0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) aw_seen <= 1'b0;
        else begin
            if (m_awvalid && m_awready) aw_seen <= 1'b1;
            if (m_wvalid && m_wready)   aw_seen <= 1'b0;
        end
    end
    always @(posedge clk) begin
        if (rstn && m_wvalid && !aw_seen) early_w <= early_w + 1;
    end

    logic prev_busy = 1'b0;
    int   grant_log[$];
    always @(negedge clk) begin
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy <= busy;
    end

    function automatic logic [31:0] log_at(input int idx);
        if (idx < grant_log.size()) return 32'(grant_log[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data);
        logic aw_hs, w_hs, b_hs, done;
        tb_awaddr[m] = addr; tb_wdata[m] = data;
        tb_awvalid[m] = 1'b1; tb_wvalid[m] = 1'b1; tb_bready[m] = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            aw_hs = tb_awvalid[m] & s_awready[m];
            w_hs  = tb_wvalid[m]  & s_wready[m];
            b_hs  = tb_bready[m]  & s_bvalid[m];
            @(negedge clk);
            if (aw_hs) tb_awvalid[m] = 1'b0;
            if (w_hs)  tb_wvalid[m]  = 1'b0;
            if (b_hs) begin tb_bready[m] = 1'b0; done = 1'b1; end
        end
        check($sformatf("wr_done_m%0d", m), 32'(done), 32'd1);
    endtask

    task automatic do_read(input int m, input logic [31:0] addr, output logic [31:0] data);
        logic ar_hs, r_hs, done;
        tb_araddr[m] = addr; tb_arvalid[m] = 1'b1; tb_rready[m] = 1'b1;
        done = 1'b0; data = 32'hBAD0_BAD0;
        for (int n = 0; n < 200 && !done; n++) begin
            ar_hs = tb_arvalid[m] & s_arready[m];
            r_hs  = tb_rready[m]  & s_rvalid[m];
            if (r_hs) data = s_rdata;
            @(negedge clk);
            if (ar_hs) tb_arvalid[m] = 1'b0;
            if (r_hs) begin tb_rready[m] = 1'b0; done = 1'b1; end
        end
        check($sformatf("rd_done_m%0d", m), 32'(done), 32'd1);
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] a0[4], e0[4], a1[4], e1[4];
    logic [31:0] rd;
    int          base;

    initial begin
        for (int i = 0; i < 2; i++) begin
            tb_awvalid[i] = 0; tb_wvalid[i] = 0; tb_bready[i] = 0;
            tb_arvalid[i] = 0; tb_rready[i] = 0;
            tb_awaddr[i] = '0; tb_wdata[i] = '0; tb_araddr[i] = '0;
        end
        sl_awready = 1; sl_wready = 1; sl_arready = 1;
        rstn = 0;

        // ---- reset state, with requests present that must not leak through ----
        repeat (2) @(negedge clk);
        tb_awvalid[0] = 1; tb_arvalid[1] = 1; tb_wvalid[0] = 1;
        #1;
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_grant",    32'(grant_id), 32'd0);
        check("rst_m_valids", 32'({m_awvalid, m_wvalid, m_arvalid}), 32'd0);
        check("rst_m_readys", 32'({m_bready, m_rready}), 32'd0);
        check("rst_s_readys", 32'({s_awready, s_wready, s_arready}), 32'd0);
        check("rst_s_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
        tb_awvalid[0] = 0; tb_arvalid[1] = 0; tb_wvalid[0] = 0;
        @(negedge clk) rstn = 1;
        @(negedge clk);

        // ---- m0 writes 0xDEADBEEF to 0x08, slave stalls AW for a cycle ----
        sl_awready = 0;
        tb_awaddr[0] = 32'h08; tb_wdata[0] = 32'hDEADBEEF;
        tb_awvalid[0] = 1; tb_wvalid[0] = 1; tb_bready[0] = 1;
        @(negedge clk);
        check("t1_busy",    32'(busy), 32'd1);
        check("t1_grant",   32'(grant_id), 32'd0);
        check("t1_awvalid", 32'(m_awvalid), 32'd1);
        check("t1_awaddr",  m_awaddr, 32'h08);
        check("t1_no_early_w", 32'(m_wvalid), 32'd0);
        check("t1_awready_stall", 32'(s_awready), 32'd0);
        @(negedge clk);
        check("t1_no_early_w2", 32'(m_wvalid), 32'd0);
        sl_awready = 1;
        #1 check("t1_awready", 32'(s_awready), 32'b01);
        @(negedge clk);
        tb_awvalid[0] = 0;
        check("t1_wvalid",  32'(m_wvalid), 32'd1);
        check("t1_wdata",   m_wdata, 32'hDEADBEEF);
        check("t1_wready",  32'(s_wready), 32'b01);
        @(negedge clk);
        tb_wvalid[0] = 0;
        check("t1_bvalid",  32'(s_bvalid), 32'b01);
        check("t1_bready",  32'(m_bready), 32'd1);
        @(negedge clk);
        tb_bready[0] = 0;
        check("t1_idle",    32'(busy), 32'd0);
        check("t1_bvalid_low", 32'(s_bvalid), 32'd0);

        // ---- table of single transactions; ends with rr_ptr back at 0 ----
        vecs[0] = '{m: 1, wr: 1'b1, addr: 32'h0C, data: 32'h1111_0000};
        vecs[1] = '{m: 0, wr: 1'b0, addr: 32'h08, data: 32'hDEADBEEF};
        vecs[2] = '{m: 1, wr: 1'b0, addr: 32'h0C, data: 32'h1111_0000};
        vecs[3] = '{m: 0, wr: 1'b1, addr: 32'h10, data: 32'hA5A5_0010};
        vecs[4] = '{m: 1, wr: 1'b0, addr: 32'h00, data: 32'h0};
        for (int v = 0; v < 5; v++) begin
            base = grant_log.size();
            if (vecs[v].wr) do_write(vecs[v].m, vecs[v].addr, vecs[v].data);
            else begin
                do_read(vecs[v].m, vecs[v].addr, rd);
                check($sformatf("tbl%0d_rdata", v), rd, vecs[v].data);
            end
            check($sformatf("tbl%0d_grant", v), log_at(base), 32'(vecs[v].m));
        end

        // ---- simultaneous AW from both masters, rr_ptr=0 ----
        base = grant_log.size();
        fork
            do_write(0, 32'h14, 32'h0000_1414);
            do_write(1, 32'h18, 32'h0000_1818);
        join
        check("t2_first",  log_at(base),     32'd0);
        check("t2_second", log_at(base + 1), 32'd1);

        // ---- both masters stream 4 reads each ----
        a0 = '{32'h08, 32'h10, 32'h14, 32'h00};
        e0 = '{32'hDEADBEEF, 32'hA5A5_0010, 32'h0000_1414, 32'h0};
        a1 = '{32'h0C, 32'h18, 32'h0C, 32'h18};
        e1 = '{32'h1111_0000, 32'h0000_1818, 32'h1111_0000, 32'h0000_1818};
        base = grant_log.size();
        fork
            begin
                logic [31:0] r0;
                for (int k = 0; k < 4; k++) begin
                    do_read(0, a0[k], r0);
                    check($sformatf("t3_m0_rdata%0d", k), r0, e0[k]);
                end
            end
            begin
                logic [31:0] r1;
                for (int k = 0; k < 4; k++) begin
                    do_read(1, a1[k], r1);
                    check($sformatf("t3_m1_rdata%0d", k), r1, e1[k]);
                end
            end
        join
        for (int k = 0; k < 8; k++)
            check($sformatf("t3_grant%0d", k), log_at(base + k), 32'(k % 2));

        // ---- m1 AW and AR to 0x04 together: write first, read sees new data ----
        base = grant_log.size();
        fork
            do_write(1, 32'h04, 32'hCAFE_0004);
            do_read(1, 32'h04, rd);
        join
        check("t4_grant_wr", log_at(base),     32'd1);
        check("t4_grant_rd", log_at(base + 1), 32'd1);
        check("t4_rdata",    rd, 32'hCAFE_0004);

        // ---- reset while m1 is stuck in WR_DATA ----
        sl_wready = 0;
        tb_awaddr[1] = 32'h1C; tb_wdata[1] = 32'h5555_AAAA;
        tb_awvalid[1] = 1; tb_wvalid[1] = 1; tb_bready[1] = 1;
        @(negedge clk);
        check("t5_awvalid", 32'(m_awvalid), 32'd1);
        @(negedge clk);
        tb_awvalid[1] = 0;
        check("t5_wvalid",  32'(m_wvalid), 32'd1);
        check("t5_grant",   32'(grant_id), 32'd1);
        #2 rstn = 0;
        #1;
        check("t5_rst_busy",   32'(busy), 32'd0);
        check("t5_rst_grant",  32'(grant_id), 32'd0);
        check("t5_rst_outs",   32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
        check("t5_rst_souts",  32'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 32'd0);
        tb_wvalid[1] = 0; tb_bready[1] = 0; sl_wready = 1;
        @(negedge clk) rstn = 1;
        @(negedge clk);
        base = grant_log.size();
        do_write(0, 32'h1C, 32'h1C1C_0001);
        do_read(1, 32'h1C, rd);
        check("t5_post_grant_wr", log_at(base),     32'd0);
        check("t5_post_grant_rd", log_at(base + 1), 32'd1);
        check("t5_post_rdata",    rd, 32'h1C1C_0001);

        // ---- B held off for 10 cycles while m1 waits with an AR ----
        tb_awaddr[0] = 32'h20; tb_wdata[0] = 32'h2020_6666;
        tb_awvalid[0] = 1; tb_wvalid[0] = 1; tb_bready[0] = 0;
        tb_araddr[1] = 32'h20; tb_arvalid[1] = 1;
        @(negedge clk);
        check("t6_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        tb_awvalid[0] = 0;
        @(negedge clk);
        tb_wvalid[0] = 0;
        for (int c = 0; c < 10; c++) begin
            // {busy, grant_id, s_bvalid, m_bready, m_arvalid, s_arready}
            check($sformatf("t6_hold%0d", c),
                  32'({busy, grant_id, s_bvalid, m_bready, m_arvalid, s_arready}),
                  32'b1001_0000);
            @(negedge clk);
        end
        tb_bready[0] = 1;
        @(negedge clk);
        tb_bready[0] = 0;
        check("t6_idle", 32'(busy), 32'd0);
        base = grant_log.size();
        do_read(1, 32'h20, rd);
        check("t6_rd_grant", log_at(base), 32'd1);
        check("t6_rdata",    rd, 32'h2020_6666);

        check("w_before_aw", 32'(early_w), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
